// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, slave FSM states and default bus widths.
package axi4_lite_pkg;

   localparam int unsigned C_DATA_WIDTH = 32;
   localparam int unsigned C_ADDR_WIDTH = 32;
   localparam int unsigned C_NUM_REGS   = 16;

   typedef enum logic [2:0] {
      OKAY   = 3'd0,
      EXOKAY = 3'd1,
      SLVERR = 3'd2,
      DECERR = 3'd3
   } resp_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-lane merge: each lane takes new_data where strb is set and keeps old_data otherwise.
module axi4_lite_strb_merge #(
   parameter int unsigned P_DATA_WIDTH = 32
) (
   input  logic [P_DATA_WIDTH-1:0]   old_data,
   input  logic [P_DATA_WIDTH-1:0]   new_data,
   input  logic [P_DATA_WIDTH/8-1:0] strb,
   output logic [P_DATA_WIDTH-1:0]   merged
);

   // Per-byte select between retained and incoming data
   always_comb begin
      merged = old_data;
      for (int b = 0; b < P_DATA_WIDTH / 8; b++) begin
         if (strb[b]) begin
            merged[b*8 +: 8] = new_data[b*8 +: 8];
         end else begin
            merged[b*8 +: 8] = old_data[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register bank with byte-strobe writes, independent read/write FSMs,
// flattened register view and per-register write pulses.
module axi4_lite_slave_regfile
   import axi4_lite_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = C_DATA_WIDTH,
   parameter int unsigned P_ADDR_WIDTH = C_ADDR_WIDTH,
   parameter int unsigned P_NUM_REGS   = C_NUM_REGS
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               awvalid,
   output logic                               awready,
   input  logic [P_ADDR_WIDTH-1:0]            awaddr,
   input  logic [2:0]                         awprot,
   input  logic                               wvalid,
   output logic                               wready,
   input  logic [P_DATA_WIDTH-1:0]            wdata,
   input  logic [P_DATA_WIDTH/8-1:0]          wstrb,
   output logic                               bvalid,
   input  logic                               bready,
   output logic [2:0]                         bresp,
   input  logic                               arvalid,
   output logic                               arready,
   input  logic [P_ADDR_WIDTH-1:0]            araddr,
   input  logic [2:0]                         arprot,
   output logic                               rvalid,
   input  logic                               rready,
   output logic [P_DATA_WIDTH-1:0]            rdata,
   output logic [2:0]                         rresp,
   output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] reg_o,
   output logic [P_NUM_REGS-1:0]              reg_wr_pulse_o
);

   localparam int unsigned C_STRB_W = P_DATA_WIDTH / 8;
   localparam int unsigned C_OFFS   = $clog2(C_STRB_W);
   localparam int unsigned C_IDX_W  = $clog2(P_NUM_REGS);
   localparam logic [P_ADDR_WIDTH-1:0] C_ADDR_LIMIT = P_ADDR_WIDTH'(P_NUM_REGS * C_STRB_W);

   function automatic logic in_range(input logic [P_ADDR_WIDTH-1:0] addr);
      return addr < C_ADDR_LIMIT;
   endfunction

   logic [P_DATA_WIDTH-1:0] regs_r [P_NUM_REGS];
   wr_state_t               wr_state_r, wr_state_s;
   rd_state_t               rd_state_r, rd_state_s;
   logic                    aw_got_r, aw_got_s, w_got_r, w_got_s;
   logic [P_ADDR_WIDTH-1:0] waddr_r, waddr_s;
   logic [P_DATA_WIDTH-1:0] wdata_r, wdata_s, merged_s, rdata_s;
   logic [C_STRB_W-1:0]     wstrb_r, wstrb_s;
   logic                    awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
   logic [2:0]              bresp_s, rresp_s;
   logic                    commit_s, commit_ok_s;
   logic [C_IDX_W-1:0]      widx_s, ridx_s;
   logic [P_NUM_REGS-1:0]   pulse_s;
   logic                    prot_unused_s;

   assign prot_unused_s = ^{awprot, arprot};

   // Write channel: collect AW and W in any order, commit once both are held
   always_comb begin
      wr_state_s = wr_state_r;
      aw_got_s   = aw_got_r;
      w_got_s    = w_got_r;
      waddr_s    = (awvalid && awready) ? awaddr : waddr_r;
      wdata_s    = (wvalid && wready) ? wdata : wdata_r;
      wstrb_s    = (wvalid && wready) ? wstrb : wstrb_r;
      awready_s  = awready;
      wready_s   = wready;
      bvalid_s   = bvalid;
      bresp_s    = bresp;
      commit_s   = 1'b0;
      case (wr_state_r)
         W_IDLE: begin
            aw_got_s = aw_got_r || (awvalid && awready);
            w_got_s  = w_got_r || (wvalid && wready);
            if (aw_got_s && w_got_s) begin
               commit_s   = 1'b1;
               wr_state_s = W_RESP;
               aw_got_s   = 1'b0;
               w_got_s    = 1'b0;
               awready_s  = 1'b0;
               wready_s   = 1'b0;
               bvalid_s   = 1'b1;
               bresp_s    = in_range(waddr_s) ? OKAY : SLVERR;
            end else begin
               awready_s = !aw_got_s;
               wready_s  = !w_got_s;
            end
         end
         W_RESP: begin
            if (bready) begin
               wr_state_s = W_IDLE;
               bvalid_s   = 1'b0;
               awready_s  = 1'b1;
               wready_s   = 1'b1;
            end else begin
               bvalid_s = 1'b1;
            end
         end
         default: wr_state_s = W_IDLE;
      endcase
   end

   assign widx_s      = waddr_s[C_OFFS +: C_IDX_W];
   assign commit_ok_s = commit_s && in_range(waddr_s);
   assign pulse_s     = commit_ok_s ? (P_NUM_REGS'(1) << widx_s) : '0;

   axi4_lite_strb_merge #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_merge (
      .old_data (regs_r[widx_s]),
      .new_data (wdata_s),
      .strb     (wstrb_s),
      .merged   (merged_s)
   );

   // Read channel: snapshot the bank at the AR handshake and hold until accepted
   always_comb begin
      rd_state_s = rd_state_r;
      arready_s  = arready;
      rvalid_s   = rvalid;
      rdata_s    = rdata;
      rresp_s    = rresp;
      ridx_s     = araddr[C_OFFS +: C_IDX_W];
      case (rd_state_r)
         R_IDLE: begin
            if (arvalid && arready) begin
               rd_state_s = R_DATA;
               arready_s  = 1'b0;
               rvalid_s   = 1'b1;
               rdata_s    = in_range(araddr) ? regs_r[ridx_s] : '0;
               rresp_s    = in_range(araddr) ? OKAY : SLVERR;
            end else begin
               arready_s = 1'b1;
            end
         end
         R_DATA: begin
            if (rready) begin
               rd_state_s = R_IDLE;
               rvalid_s   = 1'b0;
               arready_s  = 1'b1;
            end else begin
               rvalid_s = 1'b1;
            end
         end
         default: rd_state_s = R_IDLE;
      endcase
   end

   // Write FSM and write-side output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_r     <= W_IDLE;
         aw_got_r       <= 1'b0;
         w_got_r        <= 1'b0;
         waddr_r        <= '0;
         wdata_r        <= '0;
         wstrb_r        <= '0;
         awready        <= 1'b0;
         wready         <= 1'b0;
         bvalid         <= 1'b0;
         bresp          <= 3'b000;
         reg_wr_pulse_o <= '0;
      end else begin
         wr_state_r     <= wr_state_s;
         aw_got_r       <= aw_got_s;
         w_got_r        <= w_got_s;
         waddr_r        <= waddr_s;
         wdata_r        <= wdata_s;
         wstrb_r        <= wstrb_s;
         awready        <= awready_s;
         wready         <= wready_s;
         bvalid         <= bvalid_s;
         bresp          <= bresp_s;
         reg_wr_pulse_o <= pulse_s;
      end
   end

   // Read FSM and read-side output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_r <= R_IDLE;
         arready    <= 1'b0;
         rvalid     <= 1'b0;
         rdata      <= '0;
         rresp      <= 3'b000;
      end else begin
         rd_state_r <= rd_state_s;
         arready    <= arready_s;
         rvalid     <= rvalid_s;
         rdata      <= rdata_s;
         rresp      <= rresp_s;
      end
   end

   // Register bank update on an in-range commit
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < P_NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (commit_ok_s) begin
         regs_r[widx_s] <= merged_s;
      end
   end

   for (genvar gi = 0; gi < P_NUM_REGS; gi++) begin : g_flat
      assign reg_o[gi*P_DATA_WIDTH +: P_DATA_WIDTH] = regs_r[gi];
   end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level register-bank model checked on every cycle.
module tb_axi4_lite_slave_regfile;

   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
   logic          arvalid = 1'b0, arready, rvalid, rready = 1'b0;
   logic [31:0]   awaddr = 32'd0, araddr = 32'd0, wdata = 32'd0, rdata;
   logic [3:0]    wstrb = 4'd0;
   logic [2:0]    awprot = 3'd0, arprot = 3'd0, bresp, rresp;
   logic [NR*32-1:0] reg_o;
   logic [NR-1:0] reg_wr_pulse_o;

   always #5 clk = ~clk;

   axi4_lite_slave_regfile #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(32), .P_NUM_REGS(NR)) dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .reg_o(reg_o), .reg_wr_pulse_o(reg_wr_pulse_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: register array, pending-request queues, response expectations
   logic [31:0] m_regs [NR];
   logic [31:0] aw_q [$];
   logic [31:0] wd_q [$];
   logic [3:0]  ws_q [$];
   bit          m_valid = 1'b0, b_pend, r_pend, after_rst;
   bit          e_awready, e_wready, e_arready;
   logic [2:0]  e_bresp, e_rresp;
   logic [31:0] e_rdata;
   logic [NR-1:0] e_pulse;

   task automatic model_check();
      chk("awready", awready, e_awready);
      chk("wready", wready, e_wready);
      chk("arready", arready, e_arready);
      chk("bvalid", bvalid, b_pend);
      chk("rvalid", rvalid, r_pend);
      if (b_pend || after_rst) chk("bresp", bresp, e_bresp);
      if (r_pend || after_rst) begin
         chk("rdata", rdata, e_rdata);
         chk("rresp", rresp, e_rresp);
      end
      chk("reg_wr_pulse", reg_wr_pulse_o, e_pulse);
      for (int i = 0; i < NR; i++) chk("reg_o", reg_o[i*32 +: 32], m_regs[i]);
   endtask

   // Predict the state after the coming posedge from the inputs it will sample
   task automatic model_step();
      bit aw_hs, w_hs, ar_hs;
      logic [31:0] a, d;
      logic [3:0] s;
      int idx;
      if (rst) begin
         for (int i = 0; i < NR; i++) m_regs[i] = 32'd0;
         aw_q.delete(); wd_q.delete(); ws_q.delete();
         b_pend = 0; r_pend = 0; after_rst = 1;
         e_awready = 0; e_wready = 0; e_arready = 0;
         e_bresp = 3'd0; e_rresp = 3'd0; e_rdata = 32'd0; e_pulse = '0;
         m_valid = 1;
      end else begin
         aw_hs = awvalid && e_awready;
         w_hs  = wvalid && e_wready;
         ar_hs = arvalid && e_arready;
         if (aw_hs) aw_q.push_back(awaddr);
         if (w_hs) begin wd_q.push_back(wdata); ws_q.push_back(wstrb); end
         e_pulse = '0;
         after_rst = 0;
         if (r_pend && rready) r_pend = 0;
         if (ar_hs) begin
            r_pend = 1;
            if (araddr < 32'd64) begin
               e_rdata = m_regs[(araddr / 4) % NR]; e_rresp = 3'b000;
            end else begin
               e_rdata = 32'd0; e_rresp = 3'b010;
            end
         end
         if (b_pend && bready) b_pend = 0;
         else if (!b_pend && aw_q.size() > 0 && wd_q.size() > 0) begin
            a = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
            b_pend = 1;
            if (a < 32'd64) begin
               idx = int'((a / 4) % NR);
               for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
               e_pulse = NR'(1) << idx;
               e_bresp = 3'b000;
            end else begin
               e_bresp = 3'b010;
            end
         end
         e_awready = !b_pend && aw_q.size() == 0;
         e_wready  = !b_pend && wd_q.size() == 0;
         e_arready = !r_pend;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) model_check();
         model_step();
      end
   end

   // Drivers start and end at posedge+1
   task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_d, input int w_d);
      int t = 0;
      bit aw_done = 0, w_done = 0, aw_now, w_now;
      awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom_range(0, 7));
      while (!(aw_done && w_done) && t < 64) begin
         awvalid = !aw_done && aw_d == 0;
         wvalid  = !w_done && w_d == 0;
         @(negedge clk);
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_now) aw_done = 1; else if (aw_d > 0) aw_d--;
         if (w_now) w_done = 1; else if (w_d > 0) w_d--;
         t++;
      end
      awvalid = 0; wvalid = 0;
      chk("write_handshake_done", 64'(aw_done && w_done), 64'd1);
   endtask

   task automatic take_b(input int stall, output logic [2:0] resp);
      int t = 0;
      bit done = 0;
      resp = 3'd7;
      while (!done && t < 64) begin
         bready = (t >= stall);
         @(negedge clk);
         if (bvalid && bready) begin done = 1; resp = bresp; end
         @(posedge clk); #1;
         t++;
      end
      bready = 0;
      chk("b_handshake_done", 64'(done), 64'd1);
   endtask

   task automatic do_read(input logic [31:0] a, input int ar_d, input int stall,
                          output logic [31:0] data, output logic [2:0] resp);
      int t = 0;
      bit done = 0, now;
      araddr = a; arprot = 3'($urandom_range(0, 7));
      data = 32'hXXXXXXXX; resp = 3'd7;
      while (!done && t < 64) begin
         arvalid = (ar_d == 0);
         @(negedge clk);
         now = arvalid && arready;
         @(posedge clk); #1;
         if (now) done = 1; else if (ar_d > 0) ar_d--;
         t++;
      end
      arvalid = 0;
      chk("ar_handshake_done", 64'(done), 64'd1);
      done = 0; t = 0;
      while (!done && t < 64) begin
         rready = (t >= stall);
         @(negedge clk);
         if (rvalid && rready) begin done = 1; data = rdata; resp = rresp; end
         @(posedge clk); #1;
         t++;
      end
      rready = 0;
      chk("r_handshake_done", 64'(done), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  r1, r2, r3;
      logic [31:0] d1, d2;
      int op, ad, wd, st;
      logic [31:0] a, d;

      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_awready_low", awready, 64'd0);
      @(posedge clk); #1;
      chk("idle_awready", awready, 64'd1);
      chk("idle_wready", wready, 64'd1);
      chk("idle_arready", arready, 64'd1);
      chk("idle_bvalid", bvalid, 64'd0);

      // Same-cycle AW+W full write
      push_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
      chk("w1_bvalid", bvalid, 64'd1);
      chk("w1_bresp", bresp, 64'd0);
      chk("w1_pulse", reg_wr_pulse_o, 64'h0004);
      chk("w1_reg2", reg_o[2*32 +: 32], 64'hDEADBEEF);
      take_b(0, r1);

      // W leads AW by three cycles, partial strobe
      push_write(32'h04, 32'h11223344, 4'h5, 3, 0);
      chk("w2_bvalid", bvalid, 64'd1);
      chk("w2_pulse", reg_wr_pulse_o, 64'h0002);
      chk("w2_reg1", reg_o[1*32 +: 32], 64'h00220044);
      take_b(2, r1);
      chk("w2_bresp", r1, 64'd0);

      // Read with a four-cycle rready stall
      do_read(32'h08, 0, 4, d1, r1);
      chk("r1_data", d1, 64'hDEADBEEF);
      chk("r1_resp", r1, 64'd0);

      // Out-of-range write and read
      push_write(32'h40, 32'h12345678, 4'hF, 0, 0);
      chk("oor_w_pulse", reg_wr_pulse_o, 64'd0);
      take_b(1, r1);
      chk("oor_bresp", r1, 64'b010);
      do_read(32'h44, 0, 0, d1, r1);
      chk("oor_rdata", d1, 64'd0);
      chk("oor_rresp", r1, 64'b010);

      // Same-cycle read and write of reg 3
      push_write(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0);
      take_b(0, r1);
      fork
         begin push_write(32'h0C, 32'h5A5A5A5A, 4'hF, 0, 0); take_b(0, r2); end
         begin do_read(32'h0C, 0, 0, d1, r3); end
      join
      chk("rw_same_old", d1, 64'hA5A5A5A5);
      do_read(32'h0C, 0, 1, d2, r1);
      chk("rw_after_new", d2, 64'h5A5A5A5A);

      // Reset while a write response is pending
      push_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0);
      chk("pre_rst_bvalid", bvalid, 64'd1);
      rst = 1;
      @(posedge clk); #1;
      chk("rst_bvalid", bvalid, 64'd0);
      chk("rst_regs", 64'(|reg_o), 64'd0);
      chk("rst_pulse", reg_wr_pulse_o, 64'd0);
      rst = 0;
      @(posedge clk); #1;
      chk("post_rst_awready", awready, 64'd1);
      chk("post_rst_wready", wready, 64'd1);
      chk("post_rst_arready", arready, 64'd1);
      bready = 1;
      repeat (3) @(posedge clk);
      #1 bready = 0;

      // Randomized traffic, model checks every cycle
      for (int n = 0; n < 250; n++) begin
         op = $urandom_range(0, 2);
         a  = 32'($urandom_range(0, 32'h4F));
         d  = $urandom;
         ad = $urandom_range(0, 3);
         wd = $urandom_range(0, 3);
         st = $urandom_range(0, 3);
         case (op)
            0: begin push_write(a, d, 4'($urandom_range(0, 15)), ad, wd); take_b(st, r1); end
            1: do_read(a, ad, st, d1, r1);
            default: fork
               begin push_write(a, d, 4'($urandom_range(0, 15)), ad, wd); take_b(st, r2); end
               begin do_read(32'($urandom_range(0, 32'h4F)), wd, ad, d2, r3); end
            join
         endcase
      end

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
- Synthesizable AXI4-Lite slave sitting directly downstream of the axi4_lite_if master side; it consumes master-driven AW/W/AR traffic and produces B/R responses.
- Implements a bank of P_NUM_REGS memory-mapped registers with byte-strobe writes.
- Exposes register contents and per-register write pulses to the surrounding fabric.
- Serves as the DUT the VIP master drives, and as a reusable CSR block.

Parameters:
- P_DATA_WIDTH, 32, data bus width in bits (32 or 64).
- P_ADDR_WIDTH, 32, address bus width in bits.
- P_NUM_REGS, 16, number of registers (power of two, at least 2).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- awvalid/awready  input/output  1/1  write address handshake.
- awaddr  input  P_ADDR_WIDTH  write byte address.
- awprot  input  3  accepted and ignored.
- wvalid/wready  input/output  1/1  write data handshake.
- wdata  input  P_DATA_WIDTH  write data.
- wstrb  input  P_DATA_WIDTH/8  byte enables.
- bvalid/bready  output/input  1/1  write response handshake.
- bresp  output  3  write response.
- arvalid/arready  input/output  1/1  read address handshake.
- araddr  input  P_ADDR_WIDTH  read byte address.
- arprot  input  3  accepted and ignored.
- rvalid/rready  output/input  1/1  read data handshake.
- rdata  output  P_DATA_WIDTH  read data.
- rresp  output  3  read response.
- reg_o  output  P_NUM_REGS*P_DATA_WIDTH  flattened register contents; reg i occupies bits [i*P_DATA_WIDTH +: P_DATA_WIDTH].
- reg_wr_pulse_o  output  P_NUM_REGS  one-cycle pulse on the committed register index.

Behaviour:
- Reset (rst=1 at posedge):
  - all registers clear to 0.
  - awready, wready, arready, bvalid and rvalid are 0 during reset.
  - bresp, rresp, rdata and reg_wr_pulse_o clear to 0.
  - both FSMs return to IDLE; any in-flight transaction is dropped without a response.
  - The first cycle after reset deasserts is IDLE with awready=wready=arready=1.
- Address decode:
  - OFFS = log2(P_DATA_WIDTH/8).
  - index = addr[OFFS +: log2(P_NUM_REGS)].
  - The low OFFS bits are ignored; unaligned addresses are treated as aligned.
  - An address is in range iff addr < P_NUM_REGS*P_DATA_WIDTH/8.
- Response encoding (3-bit, bit 2 always 0): OKAY=3'b000, SLVERR=3'b010.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, awready and wready are each held high until that channel's handshake occurs, then held low.
  - AW and W handshakes are accepted in either order or in the same cycle; the address and data/strobe are latched independently.
  - On the cycle both channels are captured, the write commits at that posedge (or the next one if the second arrives later) and the FSM goes to W_RESP.
  - Commit rule: for each byte b with wstrb[b]=1, reg[index] byte b takes the wdata byte; bytes with wstrb=0 are unchanged. reg_wr_pulse_o[index] pulses for 1 cycle. An all-zero strobe is still OKAY and still pulses.
  - An out-of-range write modifies nothing, produces no pulse, and returns bresp=SLVERR.
  - Latency: bvalid rises the cycle after the later of the two handshakes.
  - In W_RESP, bvalid and bresp are held stable until bready=1, then the FSM returns to W_IDLE with awready=wready=1 on the next cycle. There is no write pipelining (one outstanding write).
- Read FSM states: R_IDLE, R_DATA.
  - In R_IDLE, arready=1; on an arvalid handshake, rdata is latched from current register contents (value before any write committing at the same edge) and the FSM goes to R_DATA.
  - Latency: rvalid rises 1 cycle after the AR handshake.
  - An out-of-range read returns rdata=0 and rresp=SLVERR.
  - In R_DATA, arready=0; rvalid, rdata and rresp are held stable until rready=1, then the FSM returns to R_IDLE.
- Independence:
  - The read and write paths are fully concurrent; neither blocks the other.
  - For a same-register read and write in the same cycle, the read returns the old value.
- Protocol:
  - Outputs never depend combinationally on valid/ready inputs; all outputs are registered.
  - Master valid deassertion before handshake is a protocol violation; behaviour is undefined and not checked.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - resp_t 3-bit enum: OKAY, EXOKAY, SLVERR, DECERR with values 0..3.
  - wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
  - The default width localparams.
- One natural sub-module: axi4_lite_strb_merge, a parameterized byte-lane merge of old data, new data and strobe, reused by future memory slaves.
- The FSMs stay in the top module.

Test Plan:
- Reset, then an AW+W same-cycle write to 0x08 with 0xDEADBEEF, wstrb 0xF → bvalid the next cycle, bresp=000, reg_wr_pulse_o=0x0004, reg 2 = 0xDEADBEEF.
- W is presented 3 cycles before AW to 0x04 with data 0x11223344, wstrb 0x5 over an initial value of 0 → commit only after AW; reg 1 = 0x00220044; bvalid the cycle after the AW handshake.
- Read 0x08 with rready held low for 4 cycles → rvalid=1 the cycle after the AR handshake; rdata=0xDEADBEEF stable through the stall; arready=0 until the rready handshake.
- Write 0x40 and read 0x44 (out of range, P_NUM_REGS=16) → bresp=010 with no register change and no pulse; rresp=010 with rdata=0.
- Read and write of reg 3 (reg 3 = 0xA5A5A5A5 beforehand) with new data 0x5A5A5A5A handshake in the same cycle → rdata=0xA5A5A5A5; a subsequent read returns 0x5A5A5A5A.
- rst asserted while bvalid=1 awaiting bready → the next cycle has bvalid=0 and all registers 0; after release, awready=wready=arready=1 and no stale B response appears.
